// File: rtl/alarm_clock_fsm_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alarm_clock_fsm_if : keypad/button inputs and control strobes of the alarm FSM
// Revision 1.0
// ----------------------------------------------------------------------------
interface alarm_clock_fsm_if;
  logic       one_second;
  logic       time_button;
  logic       alarm_button;
  logic [3:0] key;
  logic       reset_count;
  logic       load_new_a;
  logic       show_a;
  logic       show_new_time;
  logic       load_new_c;
  logic       shift;

  // Front-end / environment side
  modport master (
    output one_second, time_button, alarm_button, key,
    input  reset_count, load_new_a, show_a, show_new_time, load_new_c, shift
  );

  // Control FSM side
  modport slave (
    input  one_second, time_button, alarm_button, key,
    output reset_count, load_new_a, show_a, show_new_time, load_new_c, shift
  );
endinterface
`default_nettype wire

// File: rtl/alarm_clock_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alarm_clock_fsm : Moore control FSM for the alarm-clock datapath with a
// key-entry timeout. Optional macro FSM_STATE_OUT_EN adds state_o.
// Revision 1.0
// ----------------------------------------------------------------------------
module alarm_clock_fsm #(
  parameter logic [3:0]  NOKEY   = 4'd10,
  parameter int unsigned TIMEOUT = 10
) (
  input  wire logic         clock,
  input  wire logic         reset,
`ifdef FSM_STATE_OUT_EN
  output      logic [2:0]   state_o,
`endif
  alarm_clock_fsm_if.slave  bus
);

  localparam logic [3:0] c_TIMEOUT = 4'(TIMEOUT);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_count;
  logic       w_timeout;
  logic       w_key_pressed;
  logic       w_counting;

  logic w_reset_count;
  logic w_load_new_a;
  logic w_show_a;
  logic w_show_new_time;
  logic w_load_new_c;
  logic w_shift;

  assign w_key_pressed = (bus.key != NOKEY);
  assign w_timeout     = (r_count == c_TIMEOUT);
  assign w_counting    = (r_state == KEY_WAITED) || (r_state == KEY_ENTRY);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= SHOW_TIME;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Timeout counter only runs during an entry session and saturates at TIMEOUT
  always_ff @(posedge clock) begin
    if (reset || !w_counting) begin
      r_count <= 4'd0;
    end else if (bus.one_second && !w_timeout) begin
      r_count <= r_count + 4'd1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SHOW_TIME: begin
        if (bus.alarm_button)       w_next_state = SHOW_ALARM;
        else if (w_key_pressed)     w_next_state = KEY_STORED;
      end
      KEY_STORED:                   w_next_state = KEY_WAITED;
      KEY_WAITED: begin
        if (w_timeout)              w_next_state = SHOW_TIME;
        else if (!w_key_pressed)    w_next_state = KEY_ENTRY;
      end
      KEY_ENTRY: begin
        if (w_timeout)              w_next_state = SHOW_TIME;
        else if (bus.alarm_button)  w_next_state = SET_ALARM_TIME;
        else if (bus.time_button)   w_next_state = SET_CURRENT_TIME;
        else if (w_key_pressed)     w_next_state = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!bus.alarm_button)      w_next_state = SHOW_TIME;
      end
      SET_ALARM_TIME:               w_next_state = SHOW_TIME;
      SET_CURRENT_TIME:             w_next_state = SHOW_TIME;
      default:                      w_next_state = SHOW_TIME;
    endcase
  end

  always_comb begin
    w_reset_count   = 1'b0;
    w_load_new_a    = 1'b0;
    w_show_a        = 1'b0;
    w_show_new_time = 1'b0;
    w_load_new_c    = 1'b0;
    w_shift         = 1'b0;
    case (r_state)
      KEY_STORED: begin
        w_shift       = 1'b1;
        w_reset_count = 1'b1;
      end
      KEY_ENTRY:        w_show_new_time = 1'b1;
      SHOW_ALARM:       w_show_a        = 1'b1;
      SET_ALARM_TIME:   w_load_new_a    = 1'b1;
      SET_CURRENT_TIME: w_load_new_c    = 1'b1;
      default: ;
    endcase
  end

  assign bus.reset_count   = w_reset_count;
  assign bus.load_new_a    = w_load_new_a;
  assign bus.show_a        = w_show_a;
  assign bus.show_new_time = w_show_new_time;
  assign bus.load_new_c    = w_load_new_c;
  assign bus.shift         = w_shift;

`ifdef FSM_STATE_OUT_EN
  assign state_o = r_state;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alarm_clock_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alarm_clock_fsm : directed and random checks of alarm_clock_fsm against
// a session-level reference model. Revision 1.0
// ----------------------------------------------------------------------------
module tb_alarm_clock_fsm;

  localparam logic [3:0] NOKEY   = 4'd10;
  localparam int         TIMEOUT = 10;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alarm_clock_fsm_if bus ();
`ifdef FSM_STATE_OUT_EN
  logic [2:0] state_o;
`endif

  alarm_clock_fsm #(
    .NOKEY   (NOKEY),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock   (clock),
    .reset   (reset),
`ifdef FSM_STATE_OUT_EN
    .state_o (state_o),
`endif
    .bus     (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: an entry "session" with elapsed seconds, not a state machine
  bit m_session;      // inside a key-entry session
  bit m_fresh;        // digit accepted this cycle
  bit m_wait;         // waiting for the key to be released
  bit m_alarm_view;   // alarm being displayed
  int m_load;         // 0 none, 1 alarm load strobe, 2 time load strobe
  int m_secs;         // seconds elapsed in the session

  task automatic mdl_step();
    bit kp;
    bit expired;
    kp = (bus.key != NOKEY);
    if (reset) begin
      m_session = 0; m_fresh = 0; m_wait = 0; m_alarm_view = 0; m_load = 0; m_secs = 0;
    end else if (m_load != 0) begin
      m_load = 0;
    end else if (m_alarm_view) begin
      if (!bus.alarm_button) m_alarm_view = 0;
    end else if (!m_session) begin
      if (bus.alarm_button) m_alarm_view = 1;
      else if (kp) begin
        m_session = 1; m_fresh = 1; m_wait = 1; m_secs = 0;
      end
    end else if (m_fresh) begin
      m_fresh = 0;
      m_secs  = 0;
    end else begin
      expired = (m_secs >= TIMEOUT);
      if (bus.one_second) m_secs++;
      if (expired) m_session = 0;
      else if (m_wait) begin
        if (!kp) m_wait = 0;
      end else if (bus.alarm_button) begin
        m_session = 0; m_load = 1;
      end else if (bus.time_button) begin
        m_session = 0; m_load = 2;
      end else if (kp) begin
        m_fresh = 1; m_wait = 1; m_secs = 0;
      end
    end
  endtask

  // {reset_count, load_new_a, show_a, show_new_time, load_new_c, shift}
  function automatic logic [5:0] obs();
    return {bus.reset_count, bus.load_new_a, bus.show_a,
            bus.show_new_time, bus.load_new_c, bus.shift};
  endfunction

  function automatic logic [5:0] mdl_out();
    return {m_fresh, m_load == 1, m_alarm_view,
            m_session && !m_fresh && !m_wait, m_load == 2, m_fresh};
  endfunction

  function automatic logic [2:0] mdl_code();
    if (m_load == 1)     return 3'd5;
    if (m_load == 2)     return 3'd6;
    if (m_alarm_view)    return 3'd4;
    if (!m_session)      return 3'd0;
    if (m_fresh)         return 3'd1;
    if (m_wait)          return 3'd2;
    return 3'd3;
  endfunction

  task automatic drive(input bit os, input bit tb_, input bit ab, input logic [3:0] k);
    bus.one_second   = os;
    bus.time_button  = tb_;
    bus.alarm_button = ab;
    bus.key          = k;
  endtask

  task automatic cycle();
    @(posedge clock);
    mdl_step();
    #1;
  endtask

  function automatic logic [3:0] rand_digit();
    logic [3:0] d;
    d = 4'($urandom_range(0, 14));
    if (d >= 4'd10) d = d + 4'd1;
    return d;
  endfunction

  // press a digit and release it, ending in the entry-display state
  task automatic enter_entry();
    drive(0, 0, 0, rand_digit());
    cycle();
    drive(0, 0, 0, NOKEY);
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, NOKEY);
    for (int i = 0; i < 5; i++) begin
      cycle();
      vectors++;
      if (obs() !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %b want %b", i, obs(), 6'b0);
      end
    end
`ifdef FSM_STATE_OUT_EN
    vectors++;
    if (state_o !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state_o: got %0d want 0", state_o);
    end
`endif
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      vectors++;
      if (obs() !== 6'b0) begin
        miscompares++;
        $display("FAIL idle_outputs cycle %0d: got %b want %b", i, obs(), 6'b0);
      end
    end
  endtask

  task automatic test_key_entry();
    logic [5:0] want [3] = '{6'b100001, 6'b000000, 6'b000100};
    drive(0, 0, 0, 4'd3);
    cycle();
    vectors++;
    if (obs() !== want[0]) begin
      miscompares++;
      $display("FAIL key_stored: got %b want %b", obs(), want[0]);
    end
    cycle();
    vectors++;
    if (obs() !== want[1]) begin
      miscompares++;
      $display("FAIL key_waited: got %b want %b", obs(), want[1]);
    end
    drive(0, 0, 0, NOKEY);
    cycle();
    vectors++;
    if (obs() !== want[2]) begin
      miscompares++;
      $display("FAIL key_entry: got %b want %b", obs(), want[2]);
    end
  endtask

  task automatic test_load_buttons();
    logic [5:0] strobe [3] = '{6'b000010, 6'b010000, 6'b010000};
    bit         tbtn   [3] = '{1, 0, 1};
    bit         abtn   [3] = '{0, 1, 1};
    for (int i = 0; i < 3; i++) begin
      enter_entry();
      drive(0, tbtn[i], abtn[i], NOKEY);
      cycle();
      vectors++;
      if (obs() !== strobe[i]) begin
        miscompares++;
        $display("FAIL load_strobe case %0d: got %b want %b", i, obs(), strobe[i]);
      end
      drive(0, 0, 0, NOKEY);
      cycle();
      vectors++;
      if (obs() !== 6'b0) begin
        miscompares++;
        $display("FAIL load_return case %0d: got %b want %b", i, obs(), 6'b0);
      end
    end
  endtask

  task automatic test_timeout();
    enter_entry();
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(1, 0, 0, NOKEY);
      cycle();
      vectors++;
      if (bus.show_new_time !== 1'b1) begin
        miscompares++;
        $display("FAIL timeout_hold pulse %0d: got %b want 1", i + 1, bus.show_new_time);
      end
    end
    drive(0, 0, 0, NOKEY);
    cycle();
    vectors++;
    if (obs() !== 6'b0) begin
      miscompares++;
      $display("FAIL timeout_exit: got %b want %b", obs(), 6'b0);
    end
  endtask

  task automatic test_restart();
    enter_entry();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive(1, 0, 0, NOKEY);
      cycle();
    end
    drive(0, 0, 0, 4'd5);
    cycle();
    vectors++;
    if (obs() !== 6'b100001) begin
      miscompares++;
      $display("FAIL restart_shift: got %b want %b", obs(), 6'b100001);
    end
    drive(0, 0, 0, NOKEY);
    cycle();
    cycle();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive(1, 0, 0, NOKEY);
      cycle();
      vectors++;
      if (bus.show_new_time !== 1'b1) begin
        miscompares++;
        $display("FAIL restart_hold pulse %0d: got %b want 1", i + 1, bus.show_new_time);
      end
    end
    reset = 1'b1;
    drive(0, 0, 0, NOKEY);
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_show_alarm();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, (i == 0) ? NOKEY : 4'd7);
      cycle();
      vectors++;
      if (obs() !== 6'b001000) begin
        miscompares++;
        $display("FAIL show_alarm cycle %0d: got %b want %b", i, obs(), 6'b001000);
      end
    end
    drive(0, 0, 0, NOKEY);
    cycle();
    vectors++;
    if (obs() !== 6'b0) begin
      miscompares++;
      $display("FAIL show_alarm_release: got %b want %b", obs(), 6'b0);
    end
  endtask

  task automatic test_reset_mid_entry();
    drive(0, 0, 0, 4'd2);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    vectors++;
    if (obs() !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_mid_entry: got %b want %b", obs(), 6'b0);
    end
    reset = 1'b0;
    cycle();
    vectors++;
    if (obs() !== 6'b100001) begin
      miscompares++;
      $display("FAIL held_key_after_reset: got %b want %b", obs(), 6'b100001);
    end
    drive(0, 0, 0, NOKEY);
    cycle();
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 12,
            ($urandom_range(0, 99) < 55) ? NOKEY : rand_digit());
      cycle();
      vectors++;
      if (obs() !== mdl_out()) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %b want %b", i, obs(), mdl_out());
      end
`ifdef FSM_STATE_OUT_EN
      vectors++;
      if (state_o !== mdl_code()) begin
        miscompares++;
        $display("FAIL random_state_o cycle %0d: got %0d want %0d", i, state_o, mdl_code());
      end
`endif
    end
    reset = 1'b0;
  endtask

  // the model also shadows every directed scenario
  task automatic test_model_sync();
    vectors++;
    if (obs() !== mdl_out()) begin
      miscompares++;
      $display("FAIL model_sync: got %b want %b", obs(), mdl_out());
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, NOKEY);
    test_reset();
    test_key_entry();
    test_model_sync();
    test_load_buttons();
    test_model_sync();
    test_timeout();
    test_restart();
    test_show_alarm();
    test_model_sync();
    test_reset_mid_entry();
    test_model_sync();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
